// File: rtl/mem_access_unit_pkg.sv
// Shared RISC-V definitions for the data-memory access path: width codes,
// FSM state encoding and request legality check.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the request is a legal width code for its direction and naturally aligned.
    function automatic logic req_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        logic misal;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !we;
            default:          legal = 1'b0;
        endcase
        misal = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return legal && !misal;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Selects the addressed byte/halfword lane from a memory word and extends it.
module load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {byte_off_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data_o = {24'b0, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data_o = {16'b0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one core data request, performs a single word-aligned
// memory access with timeout, and returns a one-cycle formatted response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [31:0] load_data;
    logic        accept, req_good, timeout;

    assign accept   = (state_q == ST_IDLE) && req_valid;
    assign req_good = req_ok(req_we, req_funct3, req_addr[1:0]);
    assign timeout  = (state_q == ST_ACCESS) && !mem_ready && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = req_good ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (mem_ready || timeout) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        mem_valid = (state_q == ST_ACCESS);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = (state_q == ST_RESP) && err_q;
        rsp_rdata = (state_q == ST_RESP) ? rdata_q : 32'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'b0;
        mem_wstrb = 4'b0;
        mem_wdata = 32'b0;
        if (state_q == ST_ACCESS) begin
            mem_we   = we_q;
            mem_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
                // Narrow stores replicate the data across lanes; the strobe picks the live one.
                case (f3_q[1:0])
                    2'b00: begin
                        mem_wstrb = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_wstrb = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (accept) err_d = !req_good;
            end
            ST_ACCESS: begin
                if (!mem_ready) cnt_d = cnt_q + 8'd1;
                if (timeout)    err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Request fields and load result are only observed while qualified by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'b0;
        end else if ((state_q == ST_ACCESS) && mem_ready && !we_q) begin
            rdata_q <= load_data;
        end
    end

    load_formatter u_load_formatter (
        .funct3_i   (f3_q),
        .byte_off_i (addr_q[1:0]),
        .rdata_i    (mem_rdata),
        .data_o     (load_data)
    );

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255; it is the maximum number of ACCESS cycles spent waiting for mem_ready before the access is aborted (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core requests a data access.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32I load/store width code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  formatted load data.
REQ-012 SHALL have port rsp_err  output  1  misaligned, illegal funct3 or timeout; qualified by rsp_valid.
REQ-013 SHALL have ports mem_valid  output  1, mem_ready  input  1, mem_we  output  1, mem_addr  output  32 (word-aligned, bits[1:0]=0), mem_wstrb  output  4, mem_wdata  output  32, mem_rdata  input  32.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-015 IDLE: req_ready=1; a request is accepted when req_valid=1; all req_* fields SHALL be registered on that edge.
REQ-016 On acceptance, a legal aligned request SHALL go to ACCESS; a misaligned or illegal one SHALL go directly to RESP with rsp_err=1 and no mem_valid.
REQ-017 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others illegal.
REQ-018 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-019 ACCESS: mem_valid=1 and mem_addr/mem_we/mem_wstrb/mem_wdata held stable from the latched fields until mem_ready=1; then go to RESP.
REQ-020 Store strobes: SB 0001<<addr[1:0] with byte replicated on all four lanes; SH 0011<<(2*addr[1]) with halfword replicated on both halves; SW 1111; loads drive mem_wstrb=0000.
REQ-021 Load data SHALL be captured from mem_rdata in the mem_ready cycle, lane-selected by addr[1:0], zero-extended for LBU/LHU, sign-extended for LB/LH.
REQ-022 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ready; at TIMEOUT_CYCLES the unit SHALL drop mem_valid, go to RESP, and set rsp_err=1.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in ACCESS and RESP.
REQ-024 Latency: accept at edge N, mem_valid high in cycle N+1; mem_ready seen in cycle N+1 gives rsp_valid in cycle N+2.
REQ-025 rsp_rdata SHALL be 0 for stores and for errored responses.
REQ-026 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-027 resetn=0 SHALL immediately force state IDLE, wait counter 0, and outputs req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset during ACCESS SHALL abandon the access with no response pulse after release.

Structure
REQ-029 funct3 width codes and FSM state encodings SHALL reside in the shared RISC-V package used by the control unit.
REQ-030 Load lane-select/extension SHALL be one combinational sub-module, load_formatter.

Verification
REQ-031 LW addr 0x100, mem_rdata 0xDEADBEEF, mem_ready in first ACCESS cycle -> rsp_valid two cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-032 LB addr 0x103, mem_rdata 0x80000000 -> rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-033 SH addr 0x102, wdata 0x0000ABCD -> mem_addr=0x100, mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-034 LW addr 0x101 -> no mem_valid, rsp_valid with rsp_err=1 in the cycle after acceptance.
REQ-035 TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid high exactly 4 cycles, then rsp_err=1 pulse.
REQ-036 resetn asserted mid-ACCESS -> mem_valid=0 at once; after release req_ready=1 and no rsp_valid.
